action_select_ctrl: RTL

Sequencer that chooses the next action for the Q-learning agent. On a start request it fetches the ACTIONS Q-values of the current state from the Q-table RAM, one per cycle, and tracks the running maximum and its index. It then applies an epsilon-greedy decision using an internal LFSR and returns the chosen action, the greedy action and the maximum Q-value. It sits between the agent top-level FSM and the Q-table memory. The same block also supplies max Q(s',a') for the update stage when run in greedy-only mode.

---
 rtl/action_select_ctrl.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/action_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : action_select_ctrl
// Brief    : Epsilon-greedy action selector for the Q-learning agent. Streams
//            the Q-values of one state out of the Q-table RAM, tracks the
//            running signed maximum and its index, then picks either the
//            greedy action or a pseudo-random one from a free-running LFSR.
//            In greedy-only mode it serves as the max Q(s',a') source for the
//            update stage.
// Revision : 1.0 - initial release
// ============================================================================
module action_select_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int ACTIONS       = 4,
  parameter int ACTIONS_WIDTH = 2,
  parameter int STATE_WIDTH   = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [STATE_WIDTH-1:0]               i_state,
  input  logic                                 i_greedy_only,
  input  logic [15:0]                          i_epsilon,
  output logic                                 o_rd_en,
  output logic [STATE_WIDTH+ACTIONS_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0]                i_rd_data,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [ACTIONS_WIDTH-1:0]             o_action,
  output logic [ACTIONS_WIDTH-1:0]             o_action_greedy,
  output logic [DATA_WIDTH-1:0]                o_q_max,
  output logic                                 o_explore
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Counter value of the final read of a state's action row.
  localparam logic [ACTIONS_WIDTH-1:0] LAST_CNT = ACTIONS_WIDTH'(ACTIONS - 1);
  localparam logic [ACTIONS_WIDTH-1:0] CNT_ONE  = ACTIONS_WIDTH'(1);
  localparam logic [ACTIONS_WIDTH-1:0] CNT_ZERO = '0;

  // Non-zero seed so the maximal-length sequence never locks up at zero.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]                      state;
  logic [2:0]                      state_next;

  // Request parameters captured at acceptance; the live inputs may change
  // freely while an operation is in flight.
  logic [STATE_WIDTH-1:0]          req_state;
  logic                            req_greedy_only;
  logic [15:0]                     req_epsilon;

  logic [ACTIONS_WIDTH-1:0]        fetch_cnt;
  logic                            start_accept;
  logic                            fetch_last;

  // Read-return qualification, aligned with i_rd_data.
  logic                            rd_valid;
  logic                            rd_first;
  logic [ACTIONS_WIDTH-1:0]        rd_idx;

  // Running maximum over the returned Q-values.
  logic signed [DATA_WIDTH-1:0]    max_val;
  logic [ACTIONS_WIDTH-1:0]        max_idx;
  logic                            max_load;

  logic [15:0]                     lfsr;
  logic                            lfsr_feedback;

  // Decision computed during DECIDE, registered into the result outputs.
  logic                            explore_dec;
  logic [ACTIONS_WIDTH-1:0]        action_dec;

  logic [ACTIONS_WIDTH-1:0]        action_reg;
  logic [ACTIONS_WIDTH-1:0]        action_greedy_reg;
  logic [DATA_WIDTH-1:0]           q_max_reg;
  logic                            explore_reg;

  assign start_accept = (state == ST_IDLE) && i_start;
  assign fetch_last   = (fetch_cnt == LAST_CNT);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fixed-length walk IDLE->FETCH(xACTIONS)->DRAIN->DECIDE->DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_last) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN:  state_next = ST_DECIDE;
      ST_DECIDE: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode: read strobe/address during FETCH, busy and done from state.
  always_comb begin
    o_rd_en   = 1'b0;
    o_rd_addr = '0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_FETCH: begin
        o_rd_en   = 1'b1;
        o_rd_addr = {req_state, fetch_cnt};
        o_busy    = 1'b1;
      end
      ST_DRAIN: begin
        o_busy    = 1'b1;
      end
      ST_DECIDE: begin
        o_busy    = 1'b1;
      end
      ST_DONE: begin
        o_done    = 1'b1;
      end
      default: begin
        o_rd_en   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture and fetch counter
  // --------------------------------------------------------------------------

  // Latch the request operands only on acceptance in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_state       <= '0;
      req_greedy_only <= 1'b0;
      req_epsilon     <= '0;
    end else if (start_accept) begin
      req_state       <= i_state;
      req_greedy_only <= i_greedy_only;
      req_epsilon     <= i_epsilon;
    end
  end

  // Action index of the current read; cleared on acceptance, steps during FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= CNT_ZERO;
    end else if (start_accept) begin
      fetch_cnt <= CNT_ZERO;
    end else if (state == ST_FETCH) begin
      fetch_cnt <= fetch_cnt + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Compare pipeline
  // --------------------------------------------------------------------------

  // Delay the read strobe by the fixed one-cycle RAM latency so it lines up
  // with i_rd_data; also carry the action index and a first-word marker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      rd_idx   <= '0;
    end else begin
      rd_valid <= o_rd_en;
      rd_first <= o_rd_en && (fetch_cnt == CNT_ZERO);
      rd_idx   <= fetch_cnt;
    end
  end

  // The first word loads unconditionally; later words must be strictly
  // greater so that ties keep the lowest action index.
  assign max_load = rd_valid && (rd_first || ($signed(i_rd_data) > max_val));

  // Running maximum and its index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (max_load) begin
      max_val <= $signed(i_rd_data);
      max_idx <= rd_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Exploration source
  // --------------------------------------------------------------------------

  // Taps 16,14,13,11 of a right-shifting Fibonacci register (bit 0 is tap 16).
  assign lfsr_feedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Free-running LFSR, advancing every cycle independent of the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr_feedback, lfsr[15:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Decision and result registers
  // --------------------------------------------------------------------------

  // Epsilon-greedy choice: explore when the LFSR falls below epsilon. The
  // random action may coincide with the greedy one; it still counts as explore.
  always_comb begin
    explore_dec = !req_greedy_only && (lfsr < req_epsilon);
    action_dec  = explore_dec ? lfsr[ACTIONS_WIDTH-1:0] : max_idx;
  end

  // Results update only at the end of DECIDE and hold until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      action_reg        <= '0;
      action_greedy_reg <= '0;
      q_max_reg         <= '0;
      explore_reg       <= 1'b0;
    end else if (state == ST_DECIDE) begin
      action_reg        <= action_dec;
      action_greedy_reg <= max_idx;
      q_max_reg         <= max_val;
      explore_reg       <= explore_dec;
    end
  end

  assign o_action        = action_reg;
  assign o_action_greedy = action_greedy_reg;
  assign o_q_max         = q_max_reg;
  assign o_explore       = explore_reg;

endmodule
`default_nettype wire
